// File: rtl/semaforo_pkg.sv
// Shared light encodings, error codes and monitor state type for the semaforo monitor.
package semaforo_pkg;

  localparam logic [2:0] VERDE_C    = 3'b001;
  localparam logic [2:0] AMARELO_C  = 3'b010;
  localparam logic [2:0] VERMELHO_C = 3'b100;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
  localparam logic [2:0] ERR_TRANS    = 3'd2;
  localparam logic [2:0] ERR_DUR      = 3'd3;
  localparam logic [2:0] ERR_CONFLICT = 3'd4;
  localparam logic [2:0] ERR_TRANS_B  = 3'd5;

  typedef enum logic {SYNC, TRACK} mon_state_t;

  function automatic logic is_legal(input logic [2:0] light);
    return (light == VERDE_C) || (light == AMARELO_C) || (light == VERMELHO_C);
  endfunction

  // Only the forward rotation green -> yellow -> red -> green is allowed.
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == VERDE_C)    && (cur == AMARELO_C))  ||
           ((prev == AMARELO_C)  && (cur == VERMELHO_C)) ||
           ((prev == VERMELHO_C) && (cur == VERDE_C));
  endfunction

endpackage

// File: rtl/light_tracker.sv
// Registers one light code and tracks change, legality and the current run length.
module light_tracker
  import semaforo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic [2:0] light_q,
  output logic [2:0] light_prev,
  output logic       changed,
  output logic       legal,
  output logic       step_ok,
  output logic [7:0] run_cnt
);

  // run_cnt holds how many samples of the current run precede this one,
  // so on a change it equals the length of the run that just ended.
  always_ff @(posedge clk) begin
    if (!rst) begin
      light_q    <= VERMELHO_C;
      light_prev <= VERMELHO_C;
      run_cnt    <= 8'd0;
    end else begin
      light_q    <= light;
      light_prev <= light_q;
      if (changed) begin
        run_cnt <= 8'd1;
      end else if (run_cnt != 8'hFF) begin
        run_cnt <= run_cnt + 8'd1;
      end
    end
  end

  assign changed = (light_q != light_prev);
  assign legal   = is_legal(light_q);
  assign step_ok = legal_step(light_prev, light_q);

endmodule

// File: rtl/semaforo_monitor.sv
// Passive safety checker on the traffic-light controller outputs.
// Defining SEMAFORO_BT_LATENCY_EN adds the bt_lat pedestrian-button latency output.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter logic [7:0] VERDE    = 8'd1,
  parameter logic [7:0] AMARELO  = 8'd3,
  parameter logic [7:0] VERMELHO = 8'd2,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic             bt,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             walk,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [7:0]       run_len
`ifdef SEMAFORO_BT_LATENCY_EN
  ,
  output logic [7:0]       bt_lat
`endif
);

  logic [2:0] a_q, a_prev, b_q;
  logic       a_chg, a_legal, a_step_ok;
  logic       b_chg, b_legal, b_step_ok;
  logic [7:0] a_run;
  logic [2:0] unused_b_prev;
  logic [7:0] unused_b_run;

  mon_state_t state;
  logic [7:0] exp_len;
  logic [2:0] err_now;

  light_tracker u_track_a (
    .clk        (clk),
    .rst        (rst),
    .light      (A),
    .light_q    (a_q),
    .light_prev (a_prev),
    .changed    (a_chg),
    .legal      (a_legal),
    .step_ok    (a_step_ok),
    .run_cnt    (a_run)
  );

  light_tracker u_track_b (
    .clk        (clk),
    .rst        (rst),
    .light      (B),
    .light_q    (b_q),
    .light_prev (unused_b_prev),
    .changed    (b_chg),
    .legal      (b_legal),
    .step_ok    (b_step_ok),
    .run_cnt    (unused_b_run)
  );

  always_comb begin
    exp_len = 8'd0;
    case (a_prev)
      VERDE_C:    exp_len = VERDE;
      AMARELO_C:  exp_len = AMARELO;
      VERMELHO_C: exp_len = VERMELHO;
      default:    exp_len = 8'd0;
    endcase
  end

  // Highest-priority fault seen on the current registered sample.
  always_comb begin
    err_now = ERR_NONE;
    if (!a_legal || !b_legal) begin
      err_now = ERR_ILLEGAL;
    end else if ((a_q != VERMELHO_C) && (b_q != VERMELHO_C)) begin
      err_now = ERR_CONFLICT;
    end else if ((state == TRACK) && a_chg && !a_step_ok) begin
      err_now = ERR_TRANS;
    end else if ((state == TRACK) && a_chg && (a_run != exp_len)) begin
      err_now = ERR_DUR;
    end else if (b_chg && !b_step_ok) begin
      err_now = ERR_TRANS_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SYNC;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      walk       <= 1'b0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
      run_len    <= 8'd0;
    end else begin
      cycle_done <= 1'b0;
      if (!err && (err_now != ERR_NONE)) begin
        err      <= 1'b1;
        err_code <= err_now;
      end
      walk <= (a_q == VERMELHO_C) && (b_q == VERMELHO_C) && !err && (err_now == ERR_NONE);
      if (a_chg) begin
        run_len <= a_run;
      end
      // The first run after reset has unknown length, so checking starts at its end.
      if (state == SYNC) begin
        if (a_chg && a_step_ok) begin
          state <= TRACK;
        end
      end else if (a_chg && (a_prev == VERMELHO_C) && (a_q == VERDE_C)) begin
        cycle_done <= 1'b1;
        cycle_cnt  <= cycle_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEMAFORO_BT_LATENCY_EN
  logic       bt_d;
  logic       bt_run;
  logic [7:0] bt_cnt;

  // Counts from a button press during green until A leaves green.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bt_d   <= 1'b0;
      bt_run <= 1'b0;
      bt_cnt <= 8'd0;
      bt_lat <= 8'd0;
    end else begin
      bt_d <= bt;
      if (bt_run && a_chg && (a_prev == VERDE_C)) begin
        bt_lat <= bt_cnt;
        bt_run <= 1'b0;
      end else if (!bt_run && bt && !bt_d && (a_q == VERDE_C)) begin
        bt_run <= 1'b1;
        bt_cnt <= 8'd0;
      end else if (bt_run && (bt_cnt != 8'hFF)) begin
        bt_cnt <= bt_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_bt;
  assign unused_bt = bt;
`endif

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: directed and randomized light sequences
// checked against a history-based reference model of the monitor rules.
module tb_semaforo_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam int CNT_W    = 16;
  localparam int VERDE    = 1;
  localparam int AMARELO  = 3;
  localparam int VERMELHO = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       A = R;
  logic [2:0]       B = R;
  logic             bt = 1'b0;
  logic             err, walk, cycle_done;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [7:0]       run_len;
`ifdef SEMAFORO_BT_LATENCY_EN
  logic [7:0]       bt_lat;
`endif

  semaforo_monitor #(
    .VERDE    (8'd1),
    .AMARELO  (8'd3),
    .VERMELHO (8'd2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .bt         (bt),
    .err        (err),
    .err_code   (err_code),
    .walk       (walk),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt),
    .run_len    (run_len)
`ifdef SEMAFORO_BT_LATENCY_EN
    ,
    .bt_lat     (bt_lat)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic             err;
    logic [2:0]       code;
    logic             walk;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rl;
    logic [7:0]       lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state: full history of A samples, B current/previous.
  logic [2:0]       hist[$];
  logic [2:0]       mb_cur, mb_prev;
  bit               m_track, m_err, m_walk, m_done, m_btprev, m_counting;
  logic [2:0]       m_code;
  logic [CNT_W-1:0] m_cnt;
  logic [7:0]       m_rl, m_lat;
  int               m_start;

  function automatic bit is_color(input logic [2:0] c);
    return (c == G) || (c == Y) || (c == R);
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      G:       return Y;
      Y:       return R;
      R:       return G;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int dur_of(input logic [2:0] c);
    case (c)
      G:       return VERDE;
      Y:       return AMARELO;
      R:       return VERMELHO;
      default: return -1;
    endcase
  endfunction

  task automatic modelClear();
    hist.delete();
    hist.push_back(R);
    mb_cur = R; mb_prev = R;
    m_track = 0; m_err = 0; m_walk = 0; m_done = 0;
    m_code = 3'd0; m_cnt = '0; m_rl = 8'd0; m_lat = 8'd0;
    m_btprev = 0; m_counting = 0; m_start = 0;
  endtask

  task automatic pushExp();
    exp_t e;
    e.due = cyc + 1; e.err = m_err; e.code = m_code; e.walk = m_walk;
    e.done = m_done; e.cnt = m_cnt; e.rl = m_rl; e.lat = m_lat;
    sb.push_back(e);
  endtask

  task automatic modelStep(input logic [2:0] a, input logic [2:0] b, input logic btv);
    logic [2:0] sa, pa, code;
    bit achg;
    int len, d;
    sa = hist[hist.size()-1];
    pa = (hist.size() > 1) ? hist[hist.size()-2] : R;
    achg = (sa != pa);
    len = 0;
    for (int i = hist.size() - 2; i >= 0; i--) begin
      if (hist[i] != pa) break;
      len++;
    end
    if (len > 255) len = 255;
    code = 3'd0;
    if (!is_color(sa) || !is_color(mb_cur)) code = 3'd1;
    else if (sa != R && mb_cur != R) code = 3'd4;
    else if (m_track && achg && succ(pa) != sa) code = 3'd2;
    else if (m_track && achg && len != dur_of(pa)) code = 3'd3;
    else if (mb_cur != mb_prev && succ(mb_prev) != mb_cur) code = 3'd5;
    if (!m_err && code != 3'd0) begin
      m_err = 1; m_code = code;
    end
    m_walk = (sa == R) && (mb_cur == R) && !m_err;
    m_done = m_track && achg && (pa == R) && (sa == G);
    if (m_done) m_cnt = m_cnt + 1'b1;
    if (achg) m_rl = 8'(len);
    if (!m_track && achg && is_color(sa) && succ(pa) == sa) m_track = 1;
    if (m_counting && achg && pa == G) begin
      d = cyc - m_start - 1;
      if (d > 255) d = 255;
      m_lat = 8'(d);
      m_counting = 0;
    end else if (!m_counting && btv && !m_btprev && sa == G) begin
      m_counting = 1;
      m_start = cyc;
    end
    pushExp();
    hist.push_back(a);
    if (hist.size() > 600) void'(hist.pop_front());
    mb_prev = mb_cur; mb_cur = b; m_btprev = btv;
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] a, input logic [2:0] b, input logic btv);
    @(negedge clk);
    rst = r; A = a; B = b; bt = btv;
    if (!r) begin
      modelClear();
      pushExp();
    end else begin
      modelStep(a, b, btv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (err !== e.err || err_code !== e.code || walk !== e.walk || cycle_done !== e.done ||
        cycle_cnt !== e.cnt || run_len !== e.rl) begin
      miscompares++;
      $display("[TB] FAIL outputs@cyc%0d: got err=%b code=%0d walk=%b done=%b cnt=%0d run_len=%0d, expected err=%b code=%0d walk=%b done=%b cnt=%0d run_len=%0d",
               cyc, err, err_code, walk, cycle_done, cycle_cnt, run_len,
               e.err, e.code, e.walk, e.done, e.cnt, e.rl);
    end
`ifdef SEMAFORO_BT_LATENCY_EN
    if (bt_lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL bt_lat@cyc%0d: got %0d, expected %0d", cyc, bt_lat, e.lat);
    end
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL stale@cyc%0d: got no check, expected check at cyc%0d", cyc, e.due);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  logic       qr[$];
  logic       qbt[$];
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  task automatic clearQ();
    qr.delete(); qa.delete(); qb.delete(); qbt.delete();
  endtask

  task automatic push(input logic r, input logic [2:0] a, input logic [2:0] b, input logic t, input int n);
    repeat (n) begin
      qr.push_back(r); qa.push_back(a); qb.push_back(b); qbt.push_back(t);
    end
  endtask

  task automatic play();
    for (int i = 0; i < qa.size(); i++) applyStimulus(qr[i], qa[i], qb[i], qbt[i]);
  endtask

  function automatic logic rbt();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic buildRandom();
    int bs, mode, idx;
    clearQ();
    push(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0, $urandom_range(1, 2));
    bs = qa.size();
    repeat ($urandom_range(0, 3)) push(1, R, R, rbt(), 1);
    repeat ($urandom_range(2, 4)) begin
      repeat (VERDE) push(1, G, R, rbt(), 1);
      repeat (AMARELO) push(1, Y, R, rbt(), 1);
      if ($urandom_range(0, 2) != 0) begin
        push(1, R, G, rbt(), VERMELHO - 1);
        push(1, R, Y, rbt(), 1);
      end else begin
        push(1, R, R, rbt(), VERMELHO);
      end
    end
    push(1, G, R, rbt(), 1);
    mode = $urandom_range(0, 5);
    idx = $urandom_range(bs, qa.size() - 1);
    case (mode)
      1: if ($urandom_range(0, 1) == 1) qa[idx] = 3'($urandom_range(0, 7));
         else qb[idx] = 3'($urandom_range(0, 7));
      2: begin
           qr.insert(idx, qr[idx]); qa.insert(idx, qa[idx]);
           qb.insert(idx, qb[idx]); qbt.insert(idx, qbt[idx]);
         end
      3: begin
           qr.delete(idx); qa.delete(idx); qb.delete(idx); qbt.delete(idx);
         end
      4: qr[idx] = 1'b0;
      5: qb[idx] = G;
      default: ;
    endcase
  endtask

  initial begin : stimulus
    modelClear();
    $display("[TB] start");

    // Full legal rotation: one tracked red->green, run_len 2 there.
    clearQ();
    push(0, R, R, 0, 2);
    push(1, R, R, 0, 2); push(1, G, R, 0, 1); push(1, Y, R, 0, 3);
    push(1, R, G, 0, 1); push(1, R, Y, 0, 1); push(1, G, R, 0, 1); push(1, Y, R, 0, 2);
    play();

    // Red held 5 cycles in TRACK: duration fault.
    clearQ();
    push(0, R, R, 0, 1);
    push(1, R, R, 0, 1); push(1, G, R, 0, 1); push(1, Y, R, 0, 3);
    push(1, R, R, 0, 5); push(1, G, R, 0, 2);
    play();

    // Illegal code then conflict: first code must stick.
    clearQ();
    push(0, R, R, 0, 1);
    push(1, R, R, 0, 2); push(1, 3'b011, R, 0, 1); push(1, G, G, 0, 2);
    play();

    // Both green: conflict, walk low.
    clearQ();
    push(0, R, R, 0, 1);
    push(1, R, R, 0, 1); push(1, G, G, 0, 2); push(1, R, R, 0, 2);
    play();

    // Single cycle of red/red inside a legal rotation.
    clearQ();
    push(0, R, R, 0, 1);
    push(1, G, R, 0, 1); push(1, Y, R, 0, 3); push(1, R, R, 0, 1);
    push(1, R, G, 0, 1); push(1, G, R, 0, 1);
    play();

    // Button pressed one cycle into a 4-cycle green, then reset mid-phase.
    clearQ();
    push(0, R, R, 0, 1);
    push(1, R, R, 0, 1); push(1, G, R, 0, 1); push(1, G, R, 1, 1); push(1, G, R, 0, 2);
    push(1, Y, R, 0, 2); push(0, Y, R, 0, 1); push(1, R, R, 0, 3);
    play();

    for (int ep = 0; ep < 60; ep++) begin
      buildRandom();
      play();
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending checks, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
